// File: rtl/mips_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the MIPS data port: register decode, TX FIFO, serialiser.
// Optional even-parity bit is enabled by defining UART_TX_PARITY_EN.
module mips_uart_tx #(
    parameter int unsigned             ADDR_WIDTH       = 32,
    parameter int unsigned             DATA_WIDTH       = 32,
    parameter logic [ADDR_WIDTH-1:0]   BASE_ADDR        = 32'hFFFF0000,
    parameter int unsigned             FIFO_DEPTH       = 8,
    parameter logic [15:0]             DEFAULT_BAUD_DIV = 16'd434
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] addr_mem,
    input  logic [DATA_WIDTH-1:0] wr_data_mem,
    input  logic                  wr_en_mem,
    output logic                  sel,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  tx
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    localparam logic PARITY_BIT = 1'b1;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
    localparam logic PARITY_BIT = 1'b0;
`endif

    // Register decode
    logic [1:0] offset;
    logic       wr_txdata, wr_status, wr_baud;

    assign offset    = addr_mem[3:2];
    assign sel       = (addr_mem[ADDR_WIDTH-1:4] == BASE_ADDR[ADDR_WIDTH-1:4]);
    assign wr_txdata = sel && wr_en_mem && (offset == 2'd0);
    assign wr_status = sel && wr_en_mem && (offset == 2'd1);
    assign wr_baud   = sel && wr_en_mem && (offset == 2'd2);

    logic unused_bits;
    assign unused_bits = ^{wr_data_mem[DATA_WIDTH-1:16], addr_mem[1:0]};

    logic [15:0] baud_div;
    logic        ovf_q;

    // TX FIFO
    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic             empty, full, pop, push_ok;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(FIFO_DEPTH));
    assign push_ok = wr_txdata && (!full || pop);

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wr_data_mem[7:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_div <= DEFAULT_BAUD_DIV;
            ovf_q    <= 1'b0;
        end else begin
            if (wr_baud) baud_div <= wr_data_mem[15:0];
            if (wr_txdata && full && !pop)   ovf_q <= 1'b1;
            else if (wr_status && wr_data_mem[3]) ovf_q <= 1'b0;
        end
    end

    // Serialiser FSM
    state_t      state_q, state_n;
    logic [15:0] baud_cnt_q, baud_n;
    logic [2:0]  bit_cnt_q, bit_n;
    logic [15:0] div_q, div_n;
    logic [7:0]  data_q, data_n;
    logic        tx_d, bit_end, busy;

    assign bit_end = (baud_cnt_q == div_q - 16'd1);
    assign busy    = (state_q != IDLE) || !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            div_q      <= 16'd1;
            data_q     <= '0;
            tx         <= 1'b1;
        end else begin
            state_q    <= state_n;
            baud_cnt_q <= baud_n;
            bit_cnt_q  <= bit_n;
            div_q      <= div_n;
            data_q     <= data_n;
            tx         <= tx_d;
        end
    end

    always_comb begin
        state_n = state_q;
        baud_n  = baud_cnt_q;
        bit_n   = bit_cnt_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_n = START;
                    baud_n  = '0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_n = DATA;
                    baud_n  = '0;
                    bit_n   = '0;
                end else baud_n = baud_cnt_q + 16'd1;
            end
            DATA: begin
                if (bit_end) begin
                    baud_n = '0;
                    if (bit_cnt_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                    end else bit_n = bit_cnt_q + 3'd1;
                end else baud_n = baud_cnt_q + 16'd1;
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_n = STOP;
                    baud_n  = '0;
                end else baud_n = baud_cnt_q + 16'd1;
            end
`endif
            STOP: begin
                if (bit_end) begin
                    baud_n = '0;
                    if (!empty) begin
                        pop     = 1'b1;
                        state_n = START;
                    end else state_n = IDLE;
                end else baud_n = baud_cnt_q + 16'd1;
            end
            default: begin
                state_n = IDLE;
                baud_n  = '0;
            end
        endcase
    end

    // tx is registered from the next state so a start bit appears one edge after the pop
    always_comb begin
        data_n = pop ? mem[rd_ptr] : data_q;
        div_n  = pop ? ((baud_div == 16'd0) ? 16'd1 : baud_div) : div_q;
        case (state_n)
            START:   tx_d = 1'b0;
            DATA:    tx_d = data_n[bit_n];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_d = ^data_n;
`endif
            default: tx_d = 1'b1;
        endcase
    end

    always_comb begin
        rd_data = '0;
        if (sel) begin
            case (offset)
                2'd1:    rd_data[4:0]  = {PARITY_BIT, ovf_q, empty, full, busy};
                2'd2:    rd_data[15:0] = baud_div;
                default: rd_data       = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_uart_tx.sv
// Scoreboard bench for mips_uart_tx: expected bytes are queued at store time and
// checked cycle-by-cycle against the serial waveform on tx.
module tb_mips_uart_tx;

    localparam logic [31:0] BASE   = 32'hFFFF0000;
    localparam logic [31:0] A_TX   = BASE;
    localparam logic [31:0] A_ST   = BASE + 32'd4;
    localparam logic [31:0] A_BAUD = BASE + 32'd8;
    localparam logic [31:0] A_RSV  = BASE + 32'd12;
`ifdef UART_TX_PARITY_EN
    localparam logic [31:0] PAR = 32'h10;
    localparam int FRAME_BITS = 11;
    localparam bit HAS_PAR = 1'b1;
`else
    localparam logic [31:0] PAR = 32'h0;
    localparam int FRAME_BITS = 10;
    localparam bit HAS_PAR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] addr_mem = '0;
    logic [31:0] wr_data_mem = '0;
    logic        wr_en_mem = 1'b0;
    logic        sel;
    logic [31:0] rd_data;
    logic        tx;

    int tests = 0;
    int failed = 0;
    logic [7:0] exp_q[$];

    mips_uart_tx #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .BASE_ADDR(32'hFFFF0000),
        .FIFO_DEPTH(8), .DEFAULT_BAUD_DIV(16'd434)
    ) dut (
        .clk(clk), .rst_n(rst_n), .addr_mem(addr_mem), .wr_data_mem(wr_data_mem),
        .wr_en_mem(wr_en_mem), .sel(sel), .rd_data(rd_data), .tx(tx)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        addr_mem = a; wr_data_mem = d; wr_en_mem = 1'b1;
        @(negedge clk);
        wr_en_mem = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        addr_mem = a; wr_en_mem = 1'b0;
        #1 d = rd_data;
    endtask

    task automatic check_reg(input logic [31:0] a, input logic [31:0] exp, input string name);
        logic [31:0] v;
        bus_read(a, v);
        tests++;
        if (v !== exp) begin
            failed++;
            $display("FAIL %s: got %h, expected %h", name, v, exp);
        end
    endtask

    // Waits for a start bit, then checks every clock of the frame against the queued byte.
    task automatic rx_frame(input int div, input int max_wait, input string name);
        logic [7:0] b;
        logic       exp_bit;
        bit         found;
        int         seg, bad_c;
        logic       bad_act, bad_exp;
        found = 1'b0;
        for (int w = 0; w < max_wait; w++) begin
            @(negedge clk);
            if (tx === 1'b0) begin
                found = 1'b1;
                break;
            end
        end
        tests++;
        if (!found) begin
            failed++;
            $display("FAIL %s start: tx=%b, expected 0 within %0d clks", name, tx, max_wait);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            return;
        end
        if (exp_q.size() == 0) begin
            failed++;
            $display("FAIL %s: frame seen, expected none queued", name);
            return;
        end
        b = exp_q.pop_front();
        bad_c = -1; bad_act = 1'b0; bad_exp = 1'b0;
        for (int c = 1; c < div * FRAME_BITS; c++) begin
            @(negedge clk);
            seg = c / div;
            if (seg == 0)                      exp_bit = 1'b0;
            else if (seg <= 8)                 exp_bit = b[seg-1];
            else if (HAS_PAR && seg == 9)      exp_bit = ^b;
            else                               exp_bit = 1'b1;
            if (tx !== exp_bit && bad_c < 0) begin
                bad_c = c; bad_act = tx; bad_exp = exp_bit;
            end
        end
        if (bad_c >= 0) begin
            failed++;
            $display("FAIL %s byte %h: clk %0d of frame tx=%b, expected %b", name, b, bad_c, bad_act, bad_exp);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if (tx !== 1'b1) begin
            failed++;
            $display("FAIL reset_tx: got %b, expected 1", tx);
        end
        rst_n = 1'b1;
        check_reg(A_ST, 32'h4 | PAR, "reset_status");
        check_reg(A_BAUD, 32'd434, "reset_baud");
    endtask

    task automatic test_single_byte();
        bus_write(A_BAUD, 32'd4);
        check_reg(A_BAUD, 32'd4, "baud_readback");
        exp_q.push_back(8'hA5);
        bus_write(A_TX, 32'h0000_00A5);
        tests++;
        if (tx !== 1'b1) begin
            failed++;
            $display("FAIL latency_pre: tx=%b at store edge, expected 1", tx);
        end
        rx_frame(4, 1, "single_A5");
        check_reg(A_ST, 32'h4 | PAR, "single_busy_drop");
    endtask

    task automatic test_overflow();
        bus_write(A_BAUD, 32'd100);
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    if (i < 9) exp_q.push_back(8'(8'h10 + i));
                    bus_write(A_TX, 32'h10 + i);
                end
                check_reg(A_ST, 32'hB | PAR, "ovf_set");
                bus_write(A_ST, 32'h8);
                check_reg(A_ST, 32'h3 | PAR, "ovf_clear");
            end
            begin
                rx_frame(100, 50, "ovf_first");
                for (int i = 0; i < 8; i++) rx_frame(100, 1, "ovf_drain");
            end
        join
        tests++;
        if (exp_q.size() != 0) begin
            failed++;
            $display("FAIL ovf_scoreboard: %0d bytes left, expected 0", exp_q.size());
            exp_q.delete();
        end
        check_reg(A_ST, 32'h4 | PAR, "ovf_idle");
    endtask

    // Also covers back-to-back framing: second start must follow the stop bit immediately.
    task automatic test_baud_change();
        bus_write(A_BAUD, 32'd4);
        fork
            begin
                exp_q.push_back(8'h3C);
                bus_write(A_TX, 32'h3C);
                exp_q.push_back(8'hC3);
                bus_write(A_TX, 32'h1234_56C3);
                repeat (5) @(negedge clk);
                bus_write(A_BAUD, 32'hFFFF_0008);
            end
            begin
                rx_frame(4, 20, "b2b_first_div4");
                rx_frame(8, 1, "b2b_second_div8");
            end
        join
        check_reg(A_BAUD, 32'd8, "baud_upper_masked");
    endtask

    task automatic test_baud_zero();
        bus_write(A_BAUD, 32'd0);
        check_reg(A_BAUD, 32'd0, "baud_zero_read");
        exp_q.push_back(8'h96);
        bus_write(A_TX, 32'h96);
        rx_frame(1, 1, "baud_zero_frame");
    endtask

    task automatic test_decode();
        @(negedge clk);
        addr_mem = BASE + 32'd16; wr_data_mem = 32'h55; wr_en_mem = 1'b1;
        #1;
        tests++;
        if (sel !== 1'b0 || rd_data !== 32'h0) begin
            failed++;
            $display("FAIL decode_outside: sel=%b rd=%h, expected sel=0 rd=0", sel, rd_data);
        end
        @(negedge clk);
        wr_en_mem = 1'b0;
        bus_write(BASE + 32'h18, 32'd7);
        bus_write(BASE - 32'd4, 32'd9);
        bus_write(A_RSV, 32'hFFFF_FFFF);
        check_reg(A_RSV, 32'h0, "reserved_read");
        check_reg(A_BAUD, 32'd0, "decode_baud_unchanged");
        check_reg(A_ST, 32'h4 | PAR, "decode_status_unchanged");
        check_reg(A_TX, 32'h0, "txdata_reads_zero");
        tests++;
        if (sel !== 1'b1) begin
            failed++;
            $display("FAIL decode_inside: sel=%b, expected 1", sel);
        end
    endtask

    task automatic test_midframe_reset();
        int lows;
        bus_write(A_BAUD, 32'd8);
        bus_write(A_TX, 32'h00);
        bus_write(A_TX, 32'h77);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if (tx !== 1'b1) begin
            failed++;
            $display("FAIL reset_midframe_tx: got %b, expected 1", tx);
        end
        addr_mem = A_ST;
        #1;
        tests++;
        if (rd_data !== (32'h4 | PAR)) begin
            failed++;
            $display("FAIL reset_midframe_status: got %h, expected %h", rd_data, 32'h4 | PAR);
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        lows = 0;
        repeat (40) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        tests++;
        if (lows != 0) begin
            failed++;
            $display("FAIL reset_no_resume: %0d clks with tx low, expected 0", lows);
        end
        check_reg(A_BAUD, 32'd434, "reset_midframe_baud");
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_overflow();
        test_baud_change();
        test_baud_zero();
        test_decode();
        test_midframe_reset();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
